// File: rtl/i2c_arb_pkg.sv
// Shared encodings and default widths for the I2C/host register-bank arbiter.
package i2c_arb_pkg;

    localparam int unsigned ADDR_W_DEF = 8;
    localparam int unsigned DATA_W_DEF = 16;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACCESS  = 2'd1,
        ST_CAPTURE = 2'd2
    } arb_state_e;

    typedef enum logic [2:0] {
        GNT_NONE    = 3'd0,
        GNT_I2C_WR  = 3'd1,
        GNT_I2C_RD  = 3'd2,
        GNT_HOST_RD = 3'd3,
        GNT_HOST_WR = 3'd4
    } grant_e;

endpackage

// File: rtl/i2c_reg_arbiter.sv
// Shares one single-port register bank between the I2C slave register port
// and a local host port; one bank operation per three cycles.
module i2c_reg_arbiter
    import i2c_arb_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              i2c_we,
    input  logic [ADDR_W-1:0] i2c_reg_addr,
    input  logic [DATA_W-1:0] i2c_datao,
    output logic [DATA_W-1:0] i2c_datai,
    input  logic              host_req,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic              host_ack,
    output logic [DATA_W-1:0] host_rdata,
    output logic              rf_en,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_addr,
    output logic [DATA_W-1:0] rf_wdata,
    input  logic [DATA_W-1:0] rf_rdata,
    output logic              wr_overflow
);

    arb_state_e        state;
    grant_e            grant_q;
    grant_e            pick_c;
    logic              iw_pend;
    logic [ADDR_W-1:0] iw_addr;
    logic [DATA_W-1:0] iw_data;
    logic [ADDR_W-1:0] i2c_loaded_addr;
    logic              i2c_dirty;
    logic              last_host;
    logic              h_pend_c;
    logic              ir_pend_c;
    logic              iw_clr_c;

    assign h_pend_c  = host_req && !host_ack;
    assign ir_pend_c = i2c_dirty || (i2c_reg_addr != i2c_loaded_addr);

    // Host gets the next slot after any I2C grant; otherwise iw > ir > host.
    always_comb begin
        pick_c = GNT_NONE;
        if (h_pend_c && !last_host) begin
            pick_c = host_we ? GNT_HOST_WR : GNT_HOST_RD;
        end else if (iw_pend) begin
            pick_c = GNT_I2C_WR;
        end else if (ir_pend_c) begin
            pick_c = GNT_I2C_RD;
        end else if (h_pend_c) begin
            pick_c = host_we ? GNT_HOST_WR : GNT_HOST_RD;
        end
    end

    assign iw_clr_c = (state == ST_IDLE) && (pick_c == GNT_I2C_WR);

    // One-entry write buffer; a strobe coinciding with its grant refills it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            iw_pend     <= 1'b0;
            iw_addr     <= '0;
            iw_data     <= '0;
            wr_overflow <= 1'b0;
        end else if (i2c_we) begin
            if (iw_pend && !iw_clr_c) begin
                wr_overflow <= 1'b1;
            end else begin
                iw_pend <= 1'b1;
                iw_addr <= i2c_reg_addr;
                iw_data <= i2c_datao;
            end
        end else if (iw_clr_c) begin
            iw_pend <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state           <= ST_IDLE;
            grant_q         <= GNT_NONE;
            rf_en           <= 1'b0;
            rf_we           <= 1'b0;
            rf_addr         <= '0;
            rf_wdata        <= '0;
            host_ack        <= 1'b0;
            host_rdata      <= '0;
            i2c_datai       <= '0;
            i2c_loaded_addr <= '0;
            i2c_dirty       <= 1'b1;
            last_host       <= 1'b1;
        end else begin
            host_ack <= 1'b0;
            case (state)
                ST_IDLE: begin
                    grant_q <= pick_c;
                    case (pick_c)
                        GNT_I2C_WR: begin
                            rf_en     <= 1'b1;
                            rf_we     <= 1'b1;
                            rf_addr   <= iw_addr;
                            rf_wdata  <= iw_data;
                            // Slave post-increments after a write, so re-read regardless.
                            i2c_dirty <= 1'b1;
                            last_host <= 1'b0;
                            state     <= ST_ACCESS;
                        end
                        GNT_I2C_RD: begin
                            rf_en     <= 1'b1;
                            rf_we     <= 1'b0;
                            rf_addr   <= i2c_reg_addr;
                            last_host <= 1'b0;
                            state     <= ST_ACCESS;
                        end
                        GNT_HOST_WR: begin
                            rf_en     <= 1'b1;
                            rf_we     <= 1'b1;
                            rf_addr   <= host_addr;
                            rf_wdata  <= host_wdata;
                            if (host_addr == i2c_loaded_addr) begin
                                i2c_dirty <= 1'b1;
                            end
                            last_host <= 1'b1;
                            state     <= ST_ACCESS;
                        end
                        GNT_HOST_RD: begin
                            rf_en     <= 1'b1;
                            rf_we     <= 1'b0;
                            rf_addr   <= host_addr;
                            last_host <= 1'b1;
                            state     <= ST_ACCESS;
                        end
                        default: state <= ST_IDLE;
                    endcase
                end
                ST_ACCESS: begin
                    rf_en <= 1'b0;
                    rf_we <= 1'b0;
                    state <= ST_CAPTURE;
                end
                ST_CAPTURE: begin
                    state <= ST_IDLE;
                    case (grant_q)
                        GNT_I2C_RD: begin
                            i2c_datai       <= rf_rdata;
                            i2c_loaded_addr <= rf_addr;
                            i2c_dirty       <= 1'b0;
                        end
                        GNT_HOST_RD: begin
                            host_rdata <= rf_rdata;
                            host_ack   <= 1'b1;
                        end
                        GNT_HOST_WR: host_ack <= 1'b1;
                        default: ;
                    endcase
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/i2c_reg_arbiter.md
# i2c_reg_arbiter

Shares one single-port register bank between the I2C slave's register port and a local host port. It sits between the I2C slave (`we`/`reg_addr`/`datao`/`datai`) and the register bank.
- It captures I2C write strobes into a one-entry buffer.
- It keeps the slave's read-data input refreshed to the contents of its current register address.
- It serves host reads and writes through a req/ack handshake, with bounded host latency.

## Interface
- ADDR_W, 8, register address width (matches the slave's 8-bit register address)
- DATA_W, 16, register data width (matches the slave's 16-bit data)
- clk  in  1  system clock, all logic on posedge
- reset_n  in  1  asynchronous, active-low reset
- i2c_we  in  1  single-cycle write strobe from the slave
- i2c_reg_addr  in  ADDR_W  slave register address
- i2c_datao  in  DATA_W  slave write data, valid with i2c_we
- i2c_datai  out  DATA_W  bank contents at i2c_loaded_addr, fed to the slave's datai
- host_req  in  1  host request; held high until host_ack
- host_we  in  1  host write (1) or read (0); stable while host_req is high
- host_addr  in  ADDR_W  host address
- host_wdata  in  DATA_W  host write data
- host_ack  out  1  one-cycle completion pulse
- host_rdata  out  DATA_W  read data; valid with host_ack and held until the next host read
- rf_en  out  1  bank access strobe
- rf_we  out  1  bank write
- rf_addr  out  ADDR_W  bank address
- rf_wdata  out  DATA_W  bank write data
- rf_rdata  in  DATA_W  bank read data, valid the cycle after rf_en=1 with rf_we=0
- wr_overflow  out  1  sticky: an I2C write strobe arrived while the buffer was full

## Operation
- Reset values:
  - All outputs are 0.
  - FSM is in IDLE.
  - The write buffer is empty.
  - i2c_loaded_addr=0 and i2c_dirty=1, which forces an initial refresh.
  - last_grant=HOST.
- Write buffer (one entry):
  - i2c_we=1 latches {i2c_reg_addr, i2c_datao} and sets iw_pend.
  - If iw_pend is already set and not being cleared that cycle, the new strobe is dropped and wr_overflow sets.
  - wr_overflow clears only on reset.
- Refresh request:
  - ir_pend = i2c_dirty OR (i2c_reg_addr != i2c_loaded_addr).
  - i2c_dirty sets on any granted write (either port) whose address equals i2c_loaded_addr. It also sets when the write buffer is granted, since the slave post-increments its address.
- Host request:
  - h_pend = host_req AND NOT host_ack. A host request is never regranted in its ack cycle.
- Arbitration happens in IDLE only:
  - If h_pend and last_grant≠HOST, grant HOST.
  - Otherwise priority is iw > ir > h.
  - last_grant records I2C (iw or ir) or HOST.
  - Consequence: host waits at most one I2C operation.
- FSM states:
  - IDLE: on a grant, register the rf_* outputs (rf_en=1, rf_we, rf_addr, rf_wdata) and go to ACCESS. A write grant clears iw_pend.
  - ACCESS: rf_en←0, rf_we←0; go to CAPTURE.
  - CAPTURE: go to IDLE and complete by grant type:
    - refresh: i2c_datai←rf_rdata, i2c_loaded_addr←address issued, i2c_dirty←0. If i2c_reg_addr changed during the access, ir_pend stays set.
    - host read: host_rdata←rf_rdata, host_ack←1.
    - host write: host_ack←1.
    - I2C write: nothing else.
- Refresh address is the i2c_reg_addr sampled at grant.
- A write to i2c_loaded_addr during a refresh access sets i2c_dirty after that refresh's CAPTURE, so the refresh repeats.

## Timing
- One operation occupies 3 cycles (IDLE grant edge, ACCESS, CAPTURE).
- Throughput is one operation per 3 cycles.
- Host, idle arbiter: host_req sampled at edge k → rf_en high in cycle k..k+1 → host_ack high in cycle k+2..k+3.
- Worst-case host latency to ack: 6 cycles.
- The I2C write buffer is granted within 6 cycles of i2c_we.
- The slave's minimum write spacing (more than 16 scl periods) therefore never overflows at clk ≥ 4× scl.
- Simultaneous i2c_we and a grant of the buffer: the grant consumes the old entry and the new entry is latched. No overflow.
- reset_n asserted mid-operation: immediate return to the reset values. The in-flight host request gets no ack; the host must re-request.

## Structure
- Shared package i2c_arb_pkg: state encoding (IDLE, ACCESS, CAPTURE), grant type encoding (NONE, I2C_WR, I2C_RD, HOST_RD, HOST_WR), default ADDR_W/DATA_W.
- Single module, no sub-modules. The priority picker is combinational logic inside the block.

## Test plan
- Reset then idle: after ≤3 cycles, rf_addr=0x00 is read and i2c_datai equals bank[0x00]. rf_en then stays 0.
- I2C write 0x1234 to 0x10 with i2c_reg_addr staying 0x10 afterward: bank[0x10]=0x1234, followed by a refresh, then i2c_datai=0x1234.
- Host read of 0x05 (bank=0xBEEF) on an idle arbiter: host_ack pulses exactly 3 cycles after host_req with host_rdata=0xBEEF. Holding host_req through the ack yields no second grant.
- Host_req asserted continuously while i2c_reg_addr steps 0x20→0x21→0x22 every 3 cycles: grants strictly alternate I2C/HOST, and every host ack arrives ≤6 cycles after its request.
- Two i2c_we pulses one cycle apart while a host op is in progress: wr_overflow=1, and only the first write reaches the bank.
- reset_n asserted during ACCESS of a host write: host_ack is never pulsed, and all outputs read 0 in the cycle after reset assertion.
